// File: rtl/msdap_pkg.sv
// Shared types for the MSDAP output path: one sample word per channel and the stereo pair
// that is buffered between the serial collector and the host interface.
package msdap_pkg;

    localparam int MSDAP_WORD_W = 40;

    typedef logic [MSDAP_WORD_W-1:0] msdap_word_t;

    typedef struct packed {
        msdap_word_t l;
        msdap_word_t r;
    } msdap_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_LOW
    } collector_state_t;

endpackage

// File: rtl/msdap_pair_fifo.sv
// Stereo-pair FIFO with a registered head entry; a push shows on head_vld two clocks later.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle; a pop on empty is ignored.
module msdap_pair_fifo
    import msdap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic        push,
    input  msdap_pair_t push_dat,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic        head_vld,
    output msdap_pair_t head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_ptr_n;
    logic        do_push;
    logic        do_pop;
    logic        head_vld_n;
    msdap_pair_t mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_ptr_n = do_pop ? rd_ptr + (AW+1)'(1) : rd_ptr;

    // Head is judged against the pre-push write pointer, so a new entry only
    // reaches the head register one clock after it lands in memory.
    assign head_vld_n = (rd_ptr_n != wr_ptr);

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr   <= rd_ptr_n;
            head_vld <= head_vld_n;
            head_dat <= head_vld_n ? mem[rd_ptr_n[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/msdap_output_collector.sv
// Deserializes the MSB-first OutputL/OutputR words framed by OutReady into a stereo-pair FIFO.
// Pair reaches PairValid 2 clocks after the LSB is sampled; full FIFO drops the new pair and sets Overflow.
module msdap_output_collector
    import msdap_pkg::*;
#(
    parameter int WORD_W     = MSDAP_WORD_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              SCLK,
    input  logic              Reset,
    input  logic              SampleEn,
    input  logic              OutReady,
    input  logic              OutputL,
    input  logic              OutputR,
    output logic [WORD_W-1:0] PairL,
    output logic [WORD_W-1:0] PairR,
    output logic              PairValid,
    input  logic              PairReady,
    output logic              Overflow,
    output logic              ShortWord,
    input  logic              ClearFlags
);

    localparam int CW = $clog2(WORD_W + 1);

    collector_state_t state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    msdap_word_t      shift_l, shift_l_n;
    msdap_word_t      shift_r, shift_r_n;
    logic             push;
    logic             short_set;
    logic             ovf_set;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    msdap_pair_t      push_dat;
    msdap_pair_t      head_dat;

    always_ff @(posedge SCLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shift_l <= '0;
            shift_r <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift_l <= shift_l_n;
            shift_r <= shift_r_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_l_n = shift_l;
        shift_r_n = shift_r;
        push      = 1'b0;
        short_set = 1'b0;
        case (state)
            IDLE: begin
                if (SampleEn && OutReady) begin
                    shift_l_n = {{(WORD_W-1){1'b0}}, OutputL};
                    shift_r_n = {{(WORD_W-1){1'b0}}, OutputR};
                    cnt_n     = CW'(1);
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WORD_W)) begin
                    // A sampled low in the push cycle already closes the frame.
                    push    = 1'b1;
                    state_n = (SampleEn && !OutReady) ? IDLE : WAIT_LOW;
                end else if (SampleEn) begin
                    if (OutReady) begin
                        shift_l_n = {shift_l[WORD_W-2:0], OutputL};
                        shift_r_n = {shift_r[WORD_W-2:0], OutputR};
                        cnt_n     = cnt + CW'(1);
                    end else begin
                        short_set = 1'b1;
                        shift_l_n = '0;
                        shift_r_n = '0;
                        cnt_n     = '0;
                        state_n   = IDLE;
                    end
                end
            end
            WAIT_LOW: begin
                if (SampleEn && !OutReady) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign push_dat = '{l: shift_l, r: shift_r};
    assign pop      = PairValid && PairReady && !fifo_empty;
    assign ovf_set  = push && fifo_full && !pop;

    msdap_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (SCLK),
        .rst      (Reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_vld (PairValid),
        .head_dat (head_dat)
    );

    assign PairL = head_dat.l;
    assign PairR = head_dat.r;

    // Set beats a same-cycle clear so no loss event can be hidden.
    always_ff @(posedge SCLK or posedge Reset) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            ShortWord <= 1'b0;
        end else begin
            if (ovf_set) begin
                Overflow <= 1'b1;
            end else if (ClearFlags) begin
                Overflow <= 1'b0;
            end
            if (short_set) begin
                ShortWord <= 1'b1;
            end else if (ClearFlags) begin
                ShortWord <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msdap_output_collector.sv
// Directed bench for the MSDAP output collector: framing, latency, decimated strobe, flags and FIFO edges.
module tb_msdap_output_collector;

    logic        SCLK = 1'b0;
    logic        Reset;
    logic        SampleEn;
    logic        OutReady;
    logic        OutputL;
    logic        OutputR;
    logic [39:0] PairL;
    logic [39:0] PairR;
    logic        PairValid;
    logic        PairReady;
    logic        Overflow;
    logic        ShortWord;
    logic        ClearFlags;

    int nvec = 0;
    int nerr = 0;

    localparam logic [39:0] L1 = 40'h12_3456_789A;
    localparam logic [39:0] R1 = 40'hFF_0000_0001;

    always #5 SCLK = ~SCLK;

    msdap_output_collector #(
        .WORD_W     (40),
        .FIFO_DEPTH (4)
    ) dut (
        .SCLK       (SCLK),
        .Reset      (Reset),
        .SampleEn   (SampleEn),
        .OutReady   (OutReady),
        .OutputL    (OutputL),
        .OutputR    (OutputR),
        .PairL      (PairL),
        .PairR      (PairR),
        .PairValid  (PairValid),
        .PairReady  (PairReady),
        .Overflow   (Overflow),
        .ShortWord  (ShortWord),
        .ClearFlags (ClearFlags)
    );

    function automatic logic [39:0] wl(input int i);
        return 40'hA0_0000_0000 + 40'(i) * 40'h01_0101_0101;
    endfunction

    function automatic logic [39:0] wrw(input int i);
        return ~wl(i) ^ 40'h00_0000_0005;
    endfunction

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic idle(input int n);
        SampleEn = 1'b1;
        OutReady = 1'b0;
        OutputL  = 1'b0;
        OutputR  = 1'b0;
        repeat (n) tick();
    endtask

    // Non-strobe cycles carry inverted data and random framing that must be ignored.
    task automatic send_bits(input logic [39:0] l, input logic [39:0] r, input int nbits, input int decim);
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < decim; k++) begin
                if (k == decim - 1) begin
                    SampleEn = 1'b1;
                    OutReady = 1'b1;
                    OutputL  = l[39-i];
                    OutputR  = r[39-i];
                end else begin
                    SampleEn = 1'b0;
                    OutReady = 1'($urandom_range(0, 1));
                    OutputL  = ~l[39-i];
                    OutputR  = ~r[39-i];
                end
                tick();
            end
        end
        SampleEn = 1'b1;
        OutReady = 1'b0;
        OutputL  = 1'b0;
        OutputR  = 1'b0;
    endtask

    task automatic pop_one();
        PairReady = 1'b1;
        tick();
        PairReady = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; SampleEn = 1'b0; OutReady = 1'b0; OutputL = 1'b0; OutputR = 1'b0;
        PairReady = 1'b0; ClearFlags = 1'b0;
        #1 Reset = 1'b1;
        #1;
        nvec++;
        if ({PairValid, PairL, PairR, Overflow, ShortWord} !== 83'd0) begin
            nerr++;
            $display("FAIL reset_outputs got v=%b L=%h R=%h ovf=%b sw=%b want all zero",
                     PairValid, PairL, PairR, Overflow, ShortWord);
        end
        tick(); tick();
        Reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single_word();
        send_bits(L1, R1, 40, 1);
        nvec++;
        if (PairValid !== 1'b0) begin nerr++; $display("FAIL sw_lat0 got %b want 0", PairValid); end
        tick();
        nvec++;
        if (PairValid !== 1'b0) begin nerr++; $display("FAIL sw_lat1 got %b want 0", PairValid); end
        tick();
        nvec++;
        if (PairValid !== 1'b1 || PairL !== L1 || PairR !== R1) begin
            nerr++;
            $display("FAIL sw_head got v=%b L=%h R=%h want v=1 L=%h R=%h", PairValid, PairL, PairR, L1, R1);
        end
        idle(5);
        nvec++;
        if (PairValid !== 1'b1 || PairL !== L1 || PairR !== R1) begin
            nerr++;
            $display("FAIL sw_hold got v=%b L=%h R=%h want v=1 L=%h R=%h", PairValid, PairL, PairR, L1, R1);
        end
        pop_one();
        nvec++;
        if (PairValid !== 1'b0) begin nerr++; $display("FAIL sw_pop got %b want 0", PairValid); end
    endtask

    task automatic test_decimated();
        send_bits(L1, R1, 40, 35);
        tick(); tick();
        nvec++;
        if (PairValid !== 1'b1 || PairL !== L1 || PairR !== R1) begin
            nerr++;
            $display("FAIL dec_head got v=%b L=%h R=%h want v=1 L=%h R=%h", PairValid, PairL, PairR, L1, R1);
        end
        pop_one();
        idle(3);
    endtask

    task automatic test_empty_pop();
        PairReady = 1'b1;
        idle(4);
        PairReady = 1'b0;
        nvec++;
        if (PairValid !== 1'b0) begin nerr++; $display("FAIL ep_empty got %b want 0", PairValid); end
        send_bits(wl(2), wrw(2), 40, 1);
        tick(); tick();
        nvec++;
        if (PairValid !== 1'b1 || PairL !== wl(2) || PairR !== wrw(2)) begin
            nerr++;
            $display("FAIL ep_word got v=%b L=%h R=%h want v=1 L=%h R=%h", PairValid, PairL, PairR, wl(2), wrw(2));
        end
        pop_one();
        idle(2);
    endtask

    task automatic test_short_word();
        send_bits(L1, R1, 25, 1);
        tick();
        nvec++;
        if (ShortWord !== 1'b1) begin nerr++; $display("FAIL short_flag got %b want 1", ShortWord); end
        idle(4);
        nvec++;
        if (PairValid !== 1'b0 || ShortWord !== 1'b1) begin
            nerr++;
            $display("FAIL short_nopush got v=%b sw=%b want v=0 sw=1", PairValid, ShortWord);
        end
        send_bits(wl(7), wrw(7), 40, 1);
        tick(); tick();
        nvec++;
        if (PairValid !== 1'b1 || PairL !== wl(7) || PairR !== wrw(7)) begin
            nerr++;
            $display("FAIL short_next got v=%b L=%h R=%h want v=1 L=%h R=%h", PairValid, PairL, PairR, wl(7), wrw(7));
        end
        pop_one();
        ClearFlags = 1'b1; tick(); ClearFlags = 1'b0;
        nvec++;
        if (ShortWord !== 1'b0) begin nerr++; $display("FAIL short_clear got %b want 0", ShortWord); end
        send_bits(L1, R1, 10, 1);
        ClearFlags = 1'b1; tick(); ClearFlags = 1'b0;
        nvec++;
        if (ShortWord !== 1'b1) begin nerr++; $display("FAIL short_setwins got %b want 1", ShortWord); end
        ClearFlags = 1'b1; tick(); ClearFlags = 1'b0;
        idle(2);
    endtask

    task automatic test_overflow();
        PairReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_bits(wl(i), wrw(i), 40, 1);
            idle(3);
            if (i == 4) begin
                nvec++;
                if (Overflow !== 1'b0) begin nerr++; $display("FAIL ovf_at4 got %b want 0", Overflow); end
            end
        end
        nvec++;
        if (Overflow !== 1'b1) begin nerr++; $display("FAIL ovf_at5 got %b want 1", Overflow); end
        for (int i = 1; i <= 4; i++) begin
            nvec++;
            if (PairValid !== 1'b1 || PairL !== wl(i) || PairR !== wrw(i)) begin
                nerr++;
                $display("FAIL ovf_drain%0d got v=%b L=%h R=%h want v=1 L=%h R=%h",
                         i, PairValid, PairL, PairR, wl(i), wrw(i));
            end
            pop_one();
        end
        nvec++;
        if (PairValid !== 1'b0) begin nerr++; $display("FAIL ovf_empty got %b want 0", PairValid); end
        ClearFlags = 1'b1; tick(); ClearFlags = 1'b0;
        nvec++;
        if (Overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clear got %b want 0", Overflow); end
        idle(2);
    endtask

    task automatic test_full_pop();
        for (int i = 11; i <= 14; i++) begin
            send_bits(wl(i), wrw(i), 40, 1);
            idle(3);
        end
        send_bits(wl(15), wrw(15), 40, 1);
        pop_one();
        nvec++;
        if (Overflow !== 1'b0) begin nerr++; $display("FAIL fp_noovf got %b want 0", Overflow); end
        for (int i = 12; i <= 15; i++) begin
            nvec++;
            if (PairValid !== 1'b1 || PairL !== wl(i) || PairR !== wrw(i)) begin
                nerr++;
                $display("FAIL fp_drain%0d got v=%b L=%h R=%h want v=1 L=%h R=%h",
                         i, PairValid, PairL, PairR, wl(i), wrw(i));
            end
            pop_one();
        end
        nvec++;
        if (PairValid !== 1'b0 || Overflow !== 1'b0) begin
            nerr++;
            $display("FAIL fp_count got v=%b ovf=%b want v=0 ovf=0", PairValid, Overflow);
        end
        idle(2);
    endtask

    task automatic test_reset_midframe();
        send_bits(wl(21), wrw(21), 40, 1);
        idle(3);
        send_bits(L1, R1, 10, 1);
        tick();
        idle(2);
        nvec++;
        if (PairValid !== 1'b1 || ShortWord !== 1'b1) begin
            nerr++;
            $display("FAIL rm_pre got v=%b sw=%b want v=1 sw=1", PairValid, ShortWord);
        end
        send_bits(wl(22), wrw(22), 17, 1);
        #2 Reset = 1'b1;
        #1;
        nvec++;
        if ({PairValid, PairL, PairR, Overflow, ShortWord} !== 83'd0) begin
            nerr++;
            $display("FAIL rm_async got v=%b L=%h R=%h ovf=%b sw=%b want all zero",
                     PairValid, PairL, PairR, Overflow, ShortWord);
        end
        tick();
        Reset = 1'b0;
        idle(50);
        nvec++;
        if (PairValid !== 1'b0 || ShortWord !== 1'b0 || Overflow !== 1'b0) begin
            nerr++;
            $display("FAIL rm_after got v=%b sw=%b ovf=%b want all zero", PairValid, ShortWord, Overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_decimated();
        test_empty_pop();
        test_short_word();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
